// File: rtl/out_reg_bank.sv
// Output register bank: per-channel static and timed-pulse registers with
// per-channel tristate output enables and a one-cycle write acknowledge.
module out_reg_bank #(
  parameter int N_CH = 16,
  parameter int DW   = 8,
  parameter int PW   = 8
) (
  input  logic                      CLK,
  input  logic                      CLR_n,
  input  logic                      wr_en,
  input  logic [$clog2(N_CH)-1:0]   wr_addr,
  input  logic [DW-1:0]             wr_data,
  input  logic                      wr_mode,
  input  logic [PW-1:0]             pulse_len,
  input  logic [N_CH-1:0]           oe,
  output logic [N_CH*DW-1:0]        data_out,
  output logic                      wr_ack,
  output logic                      wr_err,
  output logic [N_CH-1:0]           pulse_active
);

  localparam int AW = $clog2(N_CH);
  localparam logic [AW:0] NCH_W = (AW+1)'(N_CH);

  logic [DW-1:0] s_q [N_CH];
  logic [DW-1:0] s_d [N_CH];
  logic [DW-1:0] p_q [N_CH];
  logic [DW-1:0] p_d [N_CH];
  logic [PW-1:0] c_q [N_CH];
  logic [PW-1:0] c_d [N_CH];
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          addr_bad;

  always_comb begin
    addr_bad = ({1'b0, wr_addr} >= NCH_W);
    ack_d    = wr_en;
    err_d    = wr_en & addr_bad;
    for (int unsigned i = 0; i < N_CH; i++) begin
      s_d[i] = s_q[i];
      p_d[i] = p_q[i];
      c_d[i] = (c_q[i] != '0) ? c_q[i] - PW'(1) : c_q[i];
      // A write is applied after the decrement so a new pulse overrides expiry.
      if (wr_en && !addr_bad && (wr_addr == AW'(i))) begin
        if (wr_mode && (pulse_len != '0)) begin
          p_d[i] = wr_data;
          c_d[i] = pulse_len;
        end else begin
          s_d[i] = wr_data;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        s_q[i] <= '0;
        p_q[i] <= '0;
        c_q[i] <= '0;
      end
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        s_q[i] <= s_d[i];
        p_q[i] <= p_d[i];
        c_q[i] <= c_d[i];
      end
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  assign wr_ack = ack_q;
  assign wr_err = err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign pulse_active[g] = (c_q[g] != '0);
    assign data_out[g*DW +: DW] = oe[g] ? (pulse_active[g] ? p_q[g] : s_q[g])
                                        : {DW{1'bz}};
  end

endmodule

// File: tb/tb_out_reg_bank.sv
// Directed bench for out_reg_bank (12-channel build); acknowledges are checked
// by a scoreboard queue, channel values by hand-computed expectations.
module tb_out_reg_bank;

  localparam int N_CH = 12;
  localparam int DW   = 8;
  localparam int PW   = 8;
  localparam int AW   = 4;

  logic              CLK = 1'b0;
  logic              CLR_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_mode;
  logic [PW-1:0]     pulse_len;
  logic [N_CH-1:0]   oe;
  tri1  [N_CH*DW-1:0] dout;
  logic              wr_ack;
  logic              wr_err;
  logic [N_CH-1:0]   pa;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  bit          exp_q [$];
  logic [DW-1:0] exp_ch [N_CH];

  out_reg_bank #(.N_CH(N_CH), .DW(DW), .PW(PW)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mode(wr_mode), .pulse_len(pulse_len), .oe(oe),
    .data_out(dout), .wr_ack(wr_ack), .wr_err(wr_err), .pulse_active(pa)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] ch(input int unsigned i);
    return dout[i*DW +: DW];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_chans(input string name);
    for (int i = 0; i < N_CH; i++)
      chk($sformatf("%s_ch%0d", name, i), 32'(ch(i)), 32'(exp_ch[i]));
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic m,
                    input logic [PW-1:0] l, input bit e);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mode = m; pulse_len = l;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    wr_en = 1'b0; wr_mode = 1'b0; pulse_len = '0;
  endtask

  // Scoreboard monitor: every acknowledge must match a queued expectation.
  always @(negedge CLK) begin
    if (wr_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL ack_unexpected: got wr_ack=1 expected 0 at %0t", $time);
      end else begin
        chk("wr_err_on_ack", 32'(wr_err), 32'(exp_q.pop_front()));
      end
    end else begin
      chk("wr_err_idle", 32'(wr_err), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    CLR_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mode = 1'b0;
    pulse_len = '0; oe = '1;
    for (int i = 0; i < N_CH; i++) exp_ch[i] = '0;
    tick(); tick();
    CLR_n = 1'b1;
    tick();

    // Reset state and immediate oe response
    chk_chans("rst");
    chk("rst_pa", 32'(pa), 32'd0);
    chk("rst_ack", 32'(wr_ack), 32'd0);
    oe[3] = 1'b0; #1;
    chk("oe3_off_z", 32'(ch(3)), 32'hFF);
    oe[3] = 1'b1; #1;
    chk("oe3_on", 32'(ch(3)), 32'h00);

    // Static write
    wr(4'd5, 8'hA5, 1'b0, 8'd0, 1'b0);
    exp_ch[5] = 8'hA5;
    chk_chans("static5");

    // Pulse over static value, L = 3
    wr(4'd2, 8'h11, 1'b0, 8'd0, 1'b0);
    wr(4'd2, 8'hFF, 1'b1, 8'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("p3_val", 32'(ch(2)), 32'hFF);
      chk("p3_pa", 32'(pa[2]), 32'd1);
      tick();
    end
    chk("p3_end_val", 32'(ch(2)), 32'h11);
    chk("p3_end_pa", 32'(pa[2]), 32'd0);

    // Static write during active pulse: pulse runs out, then new static
    wr(4'd2, 8'hFF, 1'b1, 8'd4, 1'b0);
    chk("p4_c1", 32'(ch(2)), 32'hFF);
    wr(4'd2, 8'h22, 1'b0, 8'd0, 1'b0);
    chk("p4_c2", 32'(ch(2)), 32'hFF);
    tick(); chk("p4_c3", 32'(ch(2)), 32'hFF);
    tick(); chk("p4_c4", 32'(ch(2)), 32'hFF);
    tick(); chk("p4_end", 32'(ch(2)), 32'h22);
    exp_ch[2] = 8'h22;

    // Out-of-range addresses are rejected without state change
    wr(4'd12, 8'h77, 1'b0, 8'd0, 1'b1);
    wr(4'd15, 8'h77, 1'b1, 8'd5, 1'b1);
    chk_chans("badaddr");
    chk("badaddr_pa", 32'(pa), 32'd0);

    // Pulse write with L = 0 behaves as static
    wr(4'd7, 8'h3C, 1'b1, 8'd0, 1'b0);
    exp_ch[7] = 8'h3C;
    chk("l0_val", 32'(ch(7)), 32'h3C);
    chk("l0_pa", 32'(pa[7]), 32'd0);

    // Static write on the expiry edge
    wr(4'd4, 8'hAA, 1'b1, 8'd2, 1'b0);
    chk("exp_s_c1", 32'(ch(4)), 32'hAA);
    tick();
    chk("exp_s_c2", 32'(ch(4)), 32'hAA);
    wr(4'd4, 8'h44, 1'b0, 8'd0, 1'b0);
    exp_ch[4] = 8'h44;
    chk("exp_s_val", 32'(ch(4)), 32'h44);
    chk("exp_s_pa", 32'(pa[4]), 32'd0);

    // Pulse write on the expiry edge: restart with no gap
    wr(4'd6, 8'hBB, 1'b1, 8'd2, 1'b0);
    tick();
    chk("exp_p_old", 32'(ch(6)), 32'hBB);
    wr(4'd6, 8'hCC, 1'b1, 8'd2, 1'b0);
    chk("exp_p_c1", 32'(ch(6)), 32'hCC);
    chk("exp_p_pa", 32'(pa[6]), 32'd1);
    tick(); chk("exp_p_c2", 32'(ch(6)), 32'hCC);
    tick(); chk("exp_p_end", 32'(ch(6)), 32'h00);

    // Maximum pulse length
    wr(4'd8, 8'h5A, 1'b1, 8'd255, 1'b0);
    for (int k = 0; k < 254; k++) tick();
    chk("max_last_val", 32'(ch(8)), 32'h5A);
    chk("max_last_pa", 32'(pa[8]), 32'd1);
    tick();
    chk("max_end_val", 32'(ch(8)), 32'h00);
    chk("max_end_pa", 32'(pa[8]), 32'd0);
    chk_chans("isolation");

    // Reset mid-pulse with a coincident write that must be dropped
    wr(4'd0, 8'hF0, 1'b1, 8'd10, 1'b0);
    tick(); tick(); tick();
    chk("rp_active", 32'(pa[0]), 32'd1);
    CLR_n = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h99; wr_mode = 1'b0;
    tick();
    wr_en = 1'b0;
    chk("rp_ch0", 32'(ch(0)), 32'h00);
    chk("rp_pa", 32'(pa), 32'd0);
    chk("rp_ack", 32'(wr_ack), 32'd0);
    chk("rp_ch5_drv0", 32'(ch(5)), 32'h00);
    oe[5] = 1'b0; #1;
    chk("rp_ch5_z", 32'(ch(5)), 32'hFF);
    oe[5] = 1'b1;
    CLR_n = 1'b1;
    tick();
    for (int i = 0; i < N_CH; i++) exp_ch[i] = '0;
    chk_chans("post_rst");
    chk("post_rst_ack", 32'(wr_ack), 32'd0);
    tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/out_reg_bank.md
OUT_REG_BANK -- requirements
Module: out_reg_bank

Interface
REQ-001 Parameter N_CH, default 16, number of output channels (2..64).
REQ-002 Parameter DW, default 8, channel data width (1..32).
REQ-003 Parameter PW, default 8, pulse-length counter width (1..16).
REQ-004 Localparam AW = clog2(N_CH), write address width.
REQ-005 CLK  in  1  single clock; all state changes on rising edge.
REQ-006 CLR_n  in  1  reset, synchronous, active-low.
REQ-007 wr_en  in  1  write strobe, one write per asserted cycle.
REQ-008 wr_addr  in  AW  target channel.
REQ-009 wr_data  in  DW  write data.
REQ-010 wr_mode  in  1  0 = static write, 1 = timed pulse write.
REQ-011 pulse_len  in  PW  pulse duration in CLK cycles (pulse writes only).
REQ-012 oe  in  N_CH  per-channel output enable, combinational to outputs.
REQ-013 data_out  out (tri)  N_CH*DW  channel i on bits [i*DW +: DW].
REQ-014 wr_ack  out  1  one-cycle acknowledge of every write.
REQ-015 wr_err  out  1  valid with wr_ack; 1 = write rejected.
REQ-016 pulse_active  out  N_CH  channel i currently presenting pulse data.

Function
REQ-017 Per channel: static register S[i], pulse register P[i], down-counter C[i] (PW bits).
REQ-018 Channel value V[i] = P[i] when C[i] != 0, else S[i]; pulse_active[i] = (C[i] != 0).
REQ-019 data_out channel i = V[i] when oe[i] = 1, else all-Z; no latency from oe.
REQ-020 Write sampled at edge T with wr_en = 1; effect visible on V from T+1.
REQ-021 wr_ack = 1 for exactly the cycle after each sampled write; otherwise 0.
REQ-022 wr_addr >= N_CH: no state change, wr_ack = 1 and wr_err = 1.
REQ-023 wr_err = 0 whenever wr_ack = 0.
REQ-024 Static write: S[addr] <= wr_data; P/C untouched; an active pulse continues, then shows new S.
REQ-025 Pulse write, pulse_len = L > 0: P[addr] <= wr_data, C[addr] <= L; V = P for cycles T+1..T+L, returns to S at T+L+1.
REQ-026 Pulse write with pulse_len = 0: treated as static write (S updated, wr_err = 0).
REQ-027 Pulse write to channel with active pulse: restarts, new P and C = L replace old; no merge.
REQ-028 C[i] decrements by 1 each cycle while non-zero; saturates at 0, never wraps.
REQ-029 Pulse expiry (C 1->0) at the same edge as a static write to that channel: S takes new data, V = new S at T+1.
REQ-030 Pulse expiry at the same edge as a pulse write to that channel: new pulse wins, no gap cycle.
REQ-031 Writes to one channel never alter any other channel's S, P or C.
REQ-032 Maximum pulse L = 2^PW - 1 cycles.

Reset
REQ-033 CLR_n = 0 sampled at edge: all S, P, C = 0; wr_ack = 0; wr_err = 0; pulse_active = 0.
REQ-034 Write coincident with CLR_n = 0 is discarded and not acknowledged.
REQ-035 Reset mid-pulse aborts the pulse; V = 0 from next cycle.
REQ-036 data_out during reset follows oe: enabled channels drive 0, others Z.

Verification
REQ-037 Reset, oe = all 1 -> all channels 0, pulse_active = 0; oe[3] = 0 -> channel 3 Z immediately.
REQ-038 Static write ch5 = 0xA5 -> wr_ack next cycle, wr_err = 0, ch5 = 0xA5, all others unchanged.
REQ-039 S[2] = 0x11, pulse write ch2 0xFF L = 3 -> ch2 0xFF for 3 cycles, pulse_active[2] high 3 cycles, then 0x11.
REQ-040 Pulse ch2 L = 4, static write ch2 0x22 after 1 cycle -> 0xFF persists to cycle 4, then 0x22.
REQ-041 wr_addr = N_CH (N_CH = 12 build) -> wr_ack = 1, wr_err = 1, no channel changes; pulse L = 0 -> static update.
REQ-042 Pulse ch0 L = 10, CLR_n low at cycle 4 -> ch0 = 0, pulse_active[0] = 0 next cycle, no wr_ack.
